seg7_capture_decoder: RTL and testbench

- Receive side of the 7-segment display path: samples a multiplexed segment bus (8 segment lines plus one-hot digit selects).
- Debounces each digit slot, decodes each segment pattern back to a BCD digit, dot and error flag, and assembles a full frame of NDIG digits.
- Presents the frame to a consumer with a valid/ack handshake.
- Used for loopback self-test of display drivers and for reading external 7-segment panels.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_pattern_decode.sv | 30 +++
 rtl/seg7_capture_decoder.sv | 106 ++++++++++
 tb/tb_seg7_capture_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit positions, digit segment patterns and special codes for the 7-segment capture path
package seg7_pkg;
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;
  localparam logic [6:0] SEG_D0    = 7'b1111110;
  localparam logic [6:0] SEG_D1    = 7'b0110000;
  localparam logic [6:0] SEG_D2    = 7'b1101101;
  localparam logic [6:0] SEG_D3    = 7'b1111001;
  localparam logic [6:0] SEG_D4    = 7'b0110011;
  localparam logic [6:0] SEG_D5    = 7'b1011011;
  localparam logic [6:0] SEG_D6    = 7'b1011111;
  localparam logic [6:0] SEG_D7    = 7'b1110000;
  localparam logic [6:0] SEG_D8    = 7'b1111111;
  localparam logic [6:0] SEG_D9    = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000001;
  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps one a..g+dot segment pattern to a BCD code, dot and error flag
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] pat,
  output logic [3:0] code,
  output logic       dot,
  output logic       err
);
  // pattern lookup; anything outside the ten digits and the dash is flagged invalid
  always_comb begin
    code = CODE_INVALID;
    err  = 1'b0;
    dot  = pat[SEG_DP];
    case (pat[SEG_A:SEG_G])
      SEG_D0:    code = 4'd0;
      SEG_D1:    code = 4'd1;
      SEG_D2:    code = 4'd2;
      SEG_D3:    code = 4'd3;
      SEG_D4:    code = 4'd4;
      SEG_D5:    code = 4'd5;
      SEG_D6:    code = 4'd6;
      SEG_D7:    code = 4'd7;
      SEG_D8:    code = 4'd8;
      SEG_D9:    code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   err  = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: debounced capture of a multiplexed 7-segment bus into valid/ack frames; SEG7CAP_ACTIVE_LOW_EN selects common-anode (inverted) inputs
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   dot_out,
  output logic [NDIG-1:0]   err_out,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              overrun
);
  logic [7:0]        in_seg;
  logic [NDIG-1:0]   in_sel;
`ifdef SEG7CAP_ACTIVE_LOW_EN
  assign in_seg = ~seg_in;
  assign in_sel = ~dig_sel;
`else
  assign in_seg = seg_in;
  assign in_sel = dig_sel;
`endif
  logic [7:0]        s_seg_q, s_seg_d;
  logic [NDIG-1:0]   s_sel_q, s_sel_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] wbcd_q, wbcd_d, bcd_q, bcd_d;
  logic [NDIG-1:0]   wdot_q, wdot_d, werr_q, werr_d;
  logic [NDIG-1:0]   dot_q, dot_d, err_q, err_d;
  logic              fv_q, fv_d, ov_q, ov_d;
  logic              same, onehot, cap, full, load;
  logic [3:0]        dec_code;
  logic              dec_dot, dec_err;
  seg7_pattern_decode u_dec (
    .pat  (s_seg_q),
    .code (dec_code),
    .dot  (dec_dot),
    .err  (dec_err)
  );
  // stability count, capture into the working set, frame completion and handshake
  always_comb begin
    s_seg_d = in_seg;
    s_sel_d = in_sel;
    same    = (in_seg == s_seg_q) && (in_sel == s_sel_q);
    cnt_d   = !same ? 8'd0 : (cnt_q == 8'(STABLE_CYC)) ? cnt_q : cnt_q + 8'd1;
    onehot  = (s_sel_q != '0) && ((s_sel_q & (s_sel_q - 1'b1)) == '0);
    cap     = same && (cnt_q == 8'(STABLE_CYC - 1)) && onehot;
    full    = &mask_q;
    mask_d  = (full ? '0 : mask_q) | (cap ? s_sel_q : '0);
    wbcd_d  = wbcd_q;
    wdot_d  = wdot_q;
    werr_d  = werr_q;
    for (int i = 0; i < NDIG; i++)
      if (cap && s_sel_q[i]) begin
        wbcd_d[4*i+:4] = dec_code;
        wdot_d[i]      = dec_dot;
        werr_d[i]      = dec_err;
      end
    load  = full && (!fv_q || frame_ack);
    bcd_d = load ? wbcd_q : bcd_q;
    dot_d = load ? wdot_q : dot_q;
    err_d = load ? werr_q : err_q;
    fv_d  = load || (fv_q && !frame_ack);
    ov_d  = ov_q || (full && fv_q && !frame_ack);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q <= '0;
      s_sel_q <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      wbcd_q  <= '0;
      wdot_q  <= '0;
      werr_q  <= '0;
      bcd_q   <= '0;
      dot_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      s_seg_q <= s_seg_d;
      s_sel_q <= s_sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      wbcd_q  <= wbcd_d;
      wdot_q  <= wdot_d;
      werr_q  <= werr_d;
      bcd_q   <= bcd_d;
      dot_q   <= dot_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ov_q    <= ov_d;
    end
  end
  assign bcd_out     = bcd_q;
  assign dot_out     = dot_q;
  assign err_out     = err_q;
  assign frame_valid = fv_q;
  assign overrun     = ov_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder: directed frames with a scoreboard of expected frames checked by an independent monitor
module tb_seg7_capture_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] bcd_out;
  logic [3:0]  dot_out, err_out;
  logic        frame_valid, frame_ack = 1'b0, overrun;
  int pass_cnt = 0, total_cnt = 0, popped = 0, pushed = 0;
  typedef struct {logic [15:0] bcd; logic [3:0] dot; logic [3:0] err;} exp_t;
  exp_t sb[$];
  seg7_capture_decoder #(.NDIG(4), .STABLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .bcd_out(bcd_out), .dot_out(dot_out), .err_out(err_out),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic push(input logic [15:0] b, input logic [3:0] d, input logic [3:0] e);
    exp_t x;
    x.bcd = b; x.dot = d; x.err = e;
    sb.push_back(x);
    pushed++;
  endtask
  task automatic hold(input logic [3:0] sel, input logic [7:0] seg, input int n);
    dig_sel = sel;
    seg_in  = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3);
    hold(4'b0001, p0, 8);
    hold(4'b0010, p1, 8);
    hold(4'b0100, p2, 8);
    hold(4'b1000, p3, 8);
  endtask
  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    chk("fv_cleared_by_ack", 32'(frame_valid), 32'd0);
  endtask
  // monitor: a new frame is presented when valid rises or stays up right after an accepted ack
  initial begin
    logic prev_fv, prev_ack;
    exp_t e;
    prev_fv = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && frame_valid && (!prev_fv || prev_ack)) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_frame: got bcd %h expected no frame", bcd_out);
        end else begin
          e = sb.pop_front();
          popped++;
          chk("frame_bcd", 32'(bcd_out), 32'(e.bcd));
          chk("frame_dot", 32'(dot_out), 32'(e.dot));
          chk("frame_err", 32'(err_out), 32'(e.err));
        end
      end
      prev_fv = frame_valid;
      prev_ack = frame_ack;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_ov", 32'(overrun), 32'd0);
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    chk("ack_ignored_idle", 32'(frame_valid), 32'd0);
    push(16'h4321, 4'b0000, 4'b0000);
    frame(8'h60, 8'hDA, 8'hF2, 8'h66);
    chk("t1_fv", 32'(frame_valid), 32'd1);
    ack_pulse();
    hold(4'b0001, 8'hB6, 8);
    hold(4'b0010, 8'hBE, 8);
    hold(4'b1000, 8'hFC, 8);
    hold(4'b0100, 8'hF6, 3);
    hold(4'b0010, 8'hFE, 2);
    chk("t2_short_no_frame", 32'(frame_valid), 32'd0);
    push(16'h0765, 4'b0000, 4'b0000);
    hold(4'b0100, 8'hE0, 8);
    chk("t2_fv", 32'(frame_valid), 32'd1);
    ack_pulse();
    push(16'hE9F2, 4'b0010, 4'b1000);
    frame(8'hDA, 8'h03, 8'hF6, 8'h80);
    chk("t3_fv", 32'(frame_valid), 32'd1);
    ack_pulse();
    push(16'h4321, 4'b0000, 4'b0000);
    frame(8'h60, 8'hDA, 8'hF2, 8'h66);
    chk("t4_ov_before", 32'(overrun), 32'd0);
    frame(8'hB6, 8'hBE, 8'hE0, 8'hFE);
    chk("t4_ov_set", 32'(overrun), 32'd1);
    chk("t4_fv_held", 32'(frame_valid), 32'd1);
    chk("t4_first_kept", 32'(bcd_out), 32'h4321);
    push(16'h2109, 4'b0000, 4'b0000);
    hold(4'b0001, 8'hF6, 8);
    hold(4'b0010, 8'hFC, 8);
    hold(4'b0100, 8'h60, 8);
    hold(4'b1000, 8'hDA, 5);
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_fv_stays", 32'(frame_valid), 32'd1);
    chk("t4_new_data", 32'(bcd_out), 32'h2109);
    chk("t4_ov_sticky", 32'(overrun), 32'd1);
    ack_pulse();
    push(16'h6543, 4'b0000, 4'b0000);
    hold(4'b0001, 8'hF2, 8);
    hold(4'b0010, 8'h66, 8);
    hold(4'b0100, 8'hB6, 8);
    hold(4'b0110, 8'hFE, 10);
    chk("t5_multi_no_frame", 32'(frame_valid), 32'd0);
    hold(4'b1000, 8'hBE, 8);
    chk("t5_fv", 32'(frame_valid), 32'd1);
    ack_pulse();
    hold(4'b0001, 8'hE0, 8);
    hold(4'b0010, 8'hFE, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rst_bcd", 32'(bcd_out), 32'd0);
    chk("t6_rst_ov", 32'(overrun), 32'd0);
    hold(4'b0100, 8'h60, 8);
    hold(4'b1000, 8'hDA, 8);
    chk("t6_partial_no_frame", 32'(frame_valid), 32'd0);
    push(16'h2109, 4'b0000, 4'b0000);
    hold(4'b0001, 8'hF6, 8);
    hold(4'b0010, 8'hFC, 8);
    chk("t6_fv", 32'(frame_valid), 32'd1);
    ack_pulse();
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("frames_seen", 32'(popped), 32'(pushed));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
